calc_alu_seq: RTL
=================

Name: calc_alu_seq

Overview:
Parametrised multi-operation arithmetic unit for the UART calculator datapath. It supersedes the single-function add/subtract blocks.
- Triggered by the rising edge of parser_done.
- Executes ADD/SUB/MUL/DIV on two DATA_W operands: ADD/SUB in a single cycle, MUL/DIV iteratively.
- Returns a 2*DATA_W result with a one-cycle done pulse to the UART response formatter.

Parameters:
DATA_W, 16, operand width (>=4)
RES_W, 2*DATA_W, result width; derived, must not be overridden

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
parser_done  input  1  command-ready level from parser; rising edge starts an operation
op  input  2  operation: 0 ADD, 1 SUB, 2 MUL, 3 DIV
src1  input  DATA_W  operand A / dividend
src2  input  DATA_W  operand B / divisor
calc_res  output  RES_W  registered result
calc_done  output  1  one-cycle pulse, result valid
busy  output  1  high whenever FSM not IDLE
div_zero  output  1  registered flag, DIV with src2==0

Behaviour:
- Clocking and reset: one clock (clk). Reset n_rst is asynchronous, active-low.
- Reset values: calc_res=0, calc_done=0, busy=0, div_zero=0, FSM=IDLE, edge flops=0, counter=0. Reset mid-operation aborts immediately; no done pulse follows.
- Start detect: two flops, d1<=parser_done, d2<=d1; start = d1 & ~d2.
  - Level held high gives exactly one start.
  - A start seen outside IDLE is dropped, not queued.
- FSM: IDLE -> LOAD -> EXEC -> DONE -> IDLE.
  - IDLE: on start go to LOAD. src1, src2 and op are captured on that same clock edge; inputs must be stable from the parser_done rise through that edge.
  - LOAD: initialise accumulators, counter=DATA_W-1, clear div_zero.
  - EXEC:
    - ADD/SUB: 1 cycle.
    - MUL: DATA_W cycles; shift-add, one multiplier bit per cycle, LSB first.
    - DIV: DATA_W cycles; restoring, one quotient bit per cycle, MSB first.
    - DIV with src2==0: 1 cycle, no iteration.
    - Exit when counter==0 (or immediately for single-cycle cases).
  - DONE: calc_res and div_zero are registered on entry; calc_done=1 for exactly this cycle; then return to IDLE.
- Latency (start high = cycle 0): calc_done in cycle 3 for ADD/SUB and div-by-zero; cycle DATA_W+2 for MUL/DIV. A new start is accepted from the cycle after DONE.
- busy: high in LOAD, EXEC and DONE.
- Result rules (unsigned build):
  - ADD: zero-extended sum; carry lands in bit DATA_W.
  - SUB: src1 + ~src2 + 1 evaluated at RES_W with operands zero-extended; wraps modulo 2^RES_W. Example: 3-5 = all-ones-minus-one.
  - MUL: full RES_W product.
  - DIV: calc_res = {remainder[DATA_W-1:0], quotient[DATA_W-1:0]}.
  - DIV by zero: quotient = all ones, remainder = src1, div_zero=1.
- Hold: calc_res and div_zero hold their value until the next DONE. div_zero is cleared in LOAD.

Optional Feature:
CALC_SIGNED_EN
- Defined: operands are two's complement and sign-extended for ADD/SUB.
  - MUL: operates on magnitudes; product negated at DONE entry if signs differ.
  - DIV: truncates toward zero; remainder takes the dividend's sign; quotient negated if signs differ.
  - Div-by-zero result: quotient all ones, remainder src1; div_zero=1.
  - Latency unchanged.
- Undefined: unsigned behaviour as above; no sign logic synthesised.

Decomposition:
- Package calc_pkg:
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV
  - FSM state encodings ST_IDLE/ST_LOAD/ST_EXEC/ST_DONE
  - op width constant
- Sub-module calc_iter_core: shared MUL/DIV shift datapath (accumulator, shift register, counter), controlled by mode and step inputs from the top FSM.
- Top level owns edge detect, FSM and output registers.

Test Plan:
All scenarios use DATA_W=16.
1. ADD 0xFFFF+0x0001 -> calc_res=0x00010000, calc_done one cycle, 3 cycles after start; busy high cycles 1-3.
2. SUB 0x0003-0x0005 -> 0xFFFFFFFE; SUB 0x1234-0x1234 -> 0x00000000.
3. MUL 0xFFFF*0xFFFF -> 0xFFFE0001, done in cycle 18; MUL 0*0x1234 -> 0.
4. DIV 100/7 -> 0x0002000E, div_zero=0; DIV 5/0 -> 0x0005FFFF, div_zero=1, done in cycle 3; a following ADD clears div_zero.
5. parser_done held high 40 cycles, plus a second rising edge while MUL busy -> exactly one calc_done. n_rst pulsed mid-MUL -> all outputs 0 at once, FSM IDLE, no done pulse.
6. With CALC_SIGNED_EN:
   - MUL 0xFFFA*0x0003 -> 0xFFFFFFEE.
   - DIV 0xFFF9/0x0002 -> quotient 0xFFFD, remainder 0xFFFF.

Source files
------------

// File: rtl/calc_pkg.sv
// ============================================================================
// calc_pkg : shared op and FSM state encodings for the calculator ALU
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package calc_pkg;

  localparam int OP_W = 2;

  localparam logic [OP_W-1:0] OP_ADD = 2'd0;
  localparam logic [OP_W-1:0] OP_SUB = 2'd1;
  localparam logic [OP_W-1:0] OP_MUL = 2'd2;
  localparam logic [OP_W-1:0] OP_DIV = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/calc_iter_core.sv
// ============================================================================
// calc_iter_core : shared shift datapath for shift-add MUL and restoring DIV
// Rev 1.0        : initial release
// ============================================================================
`default_nettype none

module calc_iter_core #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              init,
  input  logic              step,
  input  logic              mode_div,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [DATA_W-1:0] acc_next,
  output logic [DATA_W-1:0] sreg_next,
  output logic              cnt_zero
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] sreg_q, sreg_d;
  logic [DATA_W-1:0] oper_q, oper_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    // MUL: {acc,sreg} is the partial product, multiplier consumed from sreg LSB.
    // DIV: acc is the partial remainder, sreg shifts dividend out and quotient in.
    sum     = {1'b0, acc_q} + (sreg_q[0] ? {1'b0, oper_q} : '0);
    shifted = {acc_q, sreg_q[DATA_W-1]};
    diff    = shifted - {1'b0, oper_q};
    if (mode_div) begin
      if (!diff[DATA_W]) begin
        acc_next  = diff[DATA_W-1:0];
        sreg_next = {sreg_q[DATA_W-2:0], 1'b1};
      end else begin
        acc_next  = shifted[DATA_W-1:0];
        sreg_next = {sreg_q[DATA_W-2:0], 1'b0};
      end
    end else begin
      acc_next  = sum[DATA_W:1];
      sreg_next = {sum[0], sreg_q[DATA_W-1:1]};
    end

    acc_d  = acc_q;
    sreg_d = sreg_q;
    oper_d = oper_q;
    cnt_d  = cnt_q;
    if (init) begin
      acc_d  = '0;
      sreg_d = mode_div ? opa : opb;
      oper_d = mode_div ? opb : opa;
      cnt_d  = CNT_W'(DATA_W - 1);
    end else if (step) begin
      acc_d  = acc_next;
      sreg_d = sreg_next;
      if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      acc_q  <= '0;
      sreg_q <= '0;
      oper_q <= '0;
      cnt_q  <= '0;
    end else begin
      acc_q  <= acc_d;
      sreg_q <= sreg_d;
      oper_q <= oper_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/calc_alu_seq.sv
// ============================================================================
// calc_alu_seq : sequential ADD/SUB/MUL/DIV unit started by parser_done rise
// Optional macro CALC_SIGNED_EN selects two's complement operands.
// Rev 1.0      : initial release
// ============================================================================
`default_nettype none

module calc_alu_seq
  import calc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RES_W  = 2 * DATA_W  // derived; leave at default
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              parser_done,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic [RES_W-1:0]  calc_res,
  output logic              calc_done,
  output logic              busy,
  output logic              div_zero
);

  state_t            state_q, state_d;
  logic              d1_q, d2_q;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [RES_W-1:0]  calc_res_q, calc_res_d;
  logic              calc_done_q, calc_done_d;
  logic              busy_q, busy_d;
  logic              div_zero_q, div_zero_d;

  logic              start, init, step, div0, single;
  logic [DATA_W-1:0] mag_a, mag_b, quo, rem;
  logic [DATA_W-1:0] acc_next, sreg_next;
  logic              cnt_zero;
  logic [RES_W-1:0]  ext_a, ext_b, add_res, sub_res, mul_res;
`ifdef CALC_SIGNED_EN
  logic              neg_q, neg_r;
`endif

  calc_iter_core #(.DATA_W(DATA_W)) u_core (
    .clk       (clk),
    .n_rst     (n_rst),
    .init      (init),
    .step      (step),
    .mode_div  (op_q == OP_DIV),
    .opa       (mag_a),
    .opb       (mag_b),
    .acc_next  (acc_next),
    .sreg_next (sreg_next),
    .cnt_zero  (cnt_zero)
  );

  always_comb begin
`ifdef CALC_SIGNED_EN
    // Iterate on magnitudes; signs are reapplied when the result is registered.
    neg_q   = a_q[DATA_W-1] ^ b_q[DATA_W-1];
    neg_r   = a_q[DATA_W-1];
    mag_a   = neg_r ? -a_q : a_q;
    mag_b   = b_q[DATA_W-1] ? -b_q : b_q;
    ext_a   = RES_W'($signed(a_q));
    ext_b   = RES_W'($signed(b_q));
    mul_res = neg_q ? -{acc_next, sreg_next} : {acc_next, sreg_next};
    quo     = neg_q ? -sreg_next : sreg_next;
    rem     = neg_r ? -acc_next : acc_next;
`else
    mag_a   = a_q;
    mag_b   = b_q;
    ext_a   = RES_W'(a_q);
    ext_b   = RES_W'(b_q);
    mul_res = {acc_next, sreg_next};
    quo     = sreg_next;
    rem     = acc_next;
`endif
    add_res = ext_a + ext_b;
    sub_res = ext_a + ~ext_b + RES_W'(1);
  end

  always_comb begin
    start  = d1_q & ~d2_q;
    div0   = (op_q == OP_DIV) && (b_q == '0);
    single = (op_q == OP_ADD) || (op_q == OP_SUB) || div0;

    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    calc_res_d = calc_res_q;
    div_zero_d = div_zero_q;
    init       = 1'b0;
    step       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          a_d     = src1;
          b_d     = src2;
          op_d    = op;
        end
      end
      ST_LOAD: begin
        init       = 1'b1;
        div_zero_d = 1'b0;
        state_d    = ST_EXEC;
      end
      ST_EXEC: begin
        if (single) begin
          state_d    = ST_DONE;
          div_zero_d = div0;
          if (div0)                calc_res_d = {a_q, {DATA_W{1'b1}}};
          else if (op_q == OP_ADD) calc_res_d = add_res;
          else                     calc_res_d = sub_res;
        end else begin
          step = 1'b1;
          // Last step: register the post-step value straight from the core.
          if (cnt_zero) begin
            state_d    = ST_DONE;
            calc_res_d = (op_q == OP_MUL) ? mul_res : {rem, quo};
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d      = (state_d != ST_IDLE);
    calc_done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      d1_q        <= 1'b0;
      d2_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      calc_res_q  <= '0;
      calc_done_q <= 1'b0;
      busy_q      <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      d1_q        <= parser_done;
      d2_q        <= d1_q;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      calc_res_q  <= calc_res_d;
      calc_done_q <= calc_done_d;
      busy_q      <= busy_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign calc_res  = calc_res_q;
  assign calc_done = calc_done_q;
  assign busy      = busy_q;
  assign div_zero  = div_zero_q;

endmodule

`default_nettype wire
